// File: rtl/mux_addr_sequencer.sv
// rtl/mux_addr_sequencer.sv - round-robin 4:1 analog mux address sequencer
// Selects a requesting channel, holds the select stable for SETTLE cycles, then presents it until ready.
module mux_addr_sequencer #(
  parameter int unsigned SETTLE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       req1,
  input  logic       req2,
  input  logic       req3,
  input  logic       ready,
  output logic       addr0,
  output logic       addr1,
  output logic       valid,
  output logic       busy,
  output logic [7:0] grant_count
);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SETTLE_WAIT = 2'd1,
    PRESENT     = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [1:0] addr, addr_nxt;
  logic [1:0] last_grant, last_grant_nxt;
  logic [3:0] cnt, cnt_nxt;
  logic [7:0] gcount_nxt;
  logic [3:0] reqv;
  logic [1:0] pick, ch;
  logic       hit;

  assign reqv = {req3, req2, req1, req0};

  // Scan from the farthest candidate back to the nearest so the nearest hit wins.
  always_comb begin
    pick = 2'd0;
    hit  = 1'b0;
    ch   = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      ch = last_grant + 2'd1 + 2'(i);
      if (reqv[ch]) begin
        pick = ch;
        hit  = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    addr_nxt       = addr;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;
    gcount_nxt     = grant_count;
    case (state)
      IDLE: begin
        if (hit) begin
          addr_nxt  = pick;
          cnt_nxt   = SETTLE_LOAD;
          state_nxt = SETTLE_WAIT;
        end
      end
      SETTLE_WAIT: begin
        if (cnt == 4'd0) begin
          state_nxt = PRESENT;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      PRESENT: begin
        if (ready) begin
          last_grant_nxt = addr;
          gcount_nxt     = grant_count + 8'd1;
          state_nxt      = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      addr        <= 2'd0;
      last_grant  <= 2'd3;
      cnt         <= 4'd0;
      grant_count <= 8'd0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      last_grant  <= last_grant_nxt;
      cnt         <= cnt_nxt;
      grant_count <= gcount_nxt;
    end
  end

  // valid and busy decode the state register only, so req/ready never reach them combinationally.
  assign valid = (state == PRESENT);
  assign busy  = (state != IDLE);
  assign addr0 = addr[0];
  assign addr1 = addr[1];

endmodule
